fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `num_req` write-domain requesters. It runs entirely in the FIFO write-clock domain, drives the FIFO `wr` command and write data, and honours the FIFO `full` flag so no word is offered while full. Each grant is held for a bounded burst so a requester's consecutive words stay contiguous in the FIFO.

## Interface
- `num_req`, 4, number of requesters (≥2)
- `data_width`, 8, word width
- `burst_max`, 4, max words per grant (≥1)

- `clk`  in  1  FIFO write clock; all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  num_req  bit i: requester i has a word on its data lane
- `req_data`  in  num_req*data_width  lane i = bits [i*data_width +: data_width]
- `req_ready`  out  num_req  bit i: lane i word accepted this cycle
- `fifo_full`  in  1  FIFO full flag (write domain)
- `fifo_wr`  out  1  write command to FIFO
- `fifo_wdata`  out  data_width  write data to FIFO
- `grant_id`  out  clog2(num_req)  current owner index
- `busy`  out  1  high while a grant is held (state LOCK)

## Operation
- Registers: `state` (IDLE/LOCK), `owner`, `last_grant`, `beat_cnt` (width clog2(burst_max+1)).
- Reset values: state=IDLE, owner=0, last_grant=num_req-1, beat_cnt=0. Outputs: fifo_wr=0, req_ready=0, grant_id=0, busy=0, fifo_wdata=lane 0.
- `fifo_wr` and `req_ready` are forced 0 combinationally whenever `reset`=1.
- IDLE: if any req_valid, winner = first set bit scanning last_grant+1, +2, … mod num_req; next edge: owner=winner, beat_cnt=0, state=LOCK. No transfer in IDLE.
- LOCK: xfer = req_valid[owner] & !fifo_full. fifo_wr = xfer; req_ready[owner] = xfer; other ready bits 0. fifo_wdata = lane[owner] (combinational mux, always driven).
- On xfer, beat_cnt += 1.
- Release to IDLE (last_grant=owner, beat_cnt=0) on the edge where either: xfer and beat_cnt==burst_max-1; or req_valid[owner]=0.
- fifo_full does not release a grant; owner holds LOCK while stalled and continues its burst when full clears.
- grant_id = owner; busy = (state==LOCK).
- Requesters must hold req_data stable while req_valid=1 and req_ready=0; arbiter does not check this.
- Non-owner req_valid ignored until next IDLE arbitration; no starvation: each requester waits ≤ (num_req-1) grants.

## Timing
- Arbitration latency: req_valid rising in IDLE at cycle 0 → earliest fifo_wr in cycle 1.
- Full burst: burst_max transfers in consecutive cycles when not full; one IDLE bubble after every grant. Peak throughput burst_max/(burst_max+1).
- Handshake is zero-latency: word transfers in the same cycle fifo_wr/req_ready are high; fifo_full sampled combinationally that cycle.
- fifo_full rising mid-burst: fifo_wr drops the same cycle; beat_cnt frozen; resumes the cycle full falls.
- Owner drops req_valid mid-burst: no transfer that cycle; IDLE next cycle; partial burst accepted.
- Reset asserted mid-burst: no transfer in that cycle; all registers at reset values after the edge; round-robin restarts from requester 0.
- beat_cnt never exceeds burst_max-1 in LOCK; burst_max=1 gives single-word grants.

## Test plan
- Reset: assert reset 2 cycles with all req_valid=1 → fifo_wr=0, req_ready=0, grant_id=0, busy=0 throughout; first release grants requester 0.
- Single requester: req 2 valid continuously, data 0x10..0x17, burst_max=4 → writes 0x10–0x13 cycles 1–4, IDLE cycle 5, 0x14–0x17 cycles 6–9, grant_id=2.
- Round-robin: all 4 valid continuously → grant order 0,1,2,3,0; each 4 words; one bubble between grants; no req_ready on non-owners.
- Full stall: req 1 bursting, fifo_full=1 after 2nd word for 3 cycles → fifo_wr=0 and req_ready=0 those 3 cycles, grant held, words 3–4 written immediately after full drops; exactly 4 words total.
- Early drop: req 3 deasserts req_valid after 2 words → IDLE next cycle, last_grant=3, next grant goes to lowest valid index after 3 (wrapping to 0).
- Reset mid-burst: reset during 3rd word of req 2 → that word not written (fifo_wr=0), next grant after reset goes to requester 0 if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester lanes and FIFO write port for the round-robin write arbiter.
interface fifo_wr_arbiter_if #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 8
);
   localparam int unsigned id_width = $clog2(num_req);

   logic [num_req-1:0]            req_valid;
   logic [num_req*data_width-1:0] req_data;
   logic [num_req-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr;
   logic [data_width-1:0]         fifo_wdata;
   logic [id_width-1:0]           grant_id;
   logic                          busy;

   // Arbiter side
   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr, fifo_wdata, grant_id, busy
   );

   // Requesters and FIFO side
   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr, fifo_wdata, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among requesters.
// A grant is held for up to burst_max words so a requester's words stay
// contiguous; the handshake (fifo_wr / req_ready) is zero-latency.
module fifo_wr_arbiter #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 8,
   parameter int unsigned burst_max  = 4
) (
   input  logic               clk,
   input  logic               reset,
   fifo_wr_arbiter_if.master  bus
);
   localparam int unsigned id_width  = $clog2(num_req);
   localparam int unsigned cnt_width = $clog2(burst_max + 1);
   localparam logic [cnt_width-1:0] last_beat = cnt_width'(burst_max - 1);
   localparam logic [id_width-1:0]  last_id   = id_width'(num_req - 1);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [id_width-1:0]    owner_q, owner_d;
   logic [id_width-1:0]    last_grant_q, last_grant_d;
   logic [cnt_width-1:0]   beat_q, beat_d;

   logic [data_width-1:0]  lane [num_req];
   logic [id_width-1:0]    winner;
   logic [id_width-1:0]    idx;
   logic                   any_valid;
   logic                   xfer;

   // Split the flat data bus into per-requester lanes
   for (genvar g = 0; g < num_req; g++) begin : g_lane
      assign lane[g] = bus.req_data[g*data_width +: data_width];
   end

   // Round-robin search: first valid requester after last_grant, wrapping
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int unsigned k = 1; k <= num_req; k++) begin
         idx = id_width'((32'(last_grant_q) + k) % num_req);
         if (!any_valid && bus.req_valid[idx]) begin
            winner    = idx;
            any_valid = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_grant_q <= last_id;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
      end
   end

   // Next state, grant release and the write-port handshake
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      beat_d         = beat_q;
      xfer           = 1'b0;
      bus.fifo_wr    = 1'b0;
      bus.req_ready  = '0;
      bus.fifo_wdata = lane[owner_q];
      bus.grant_id   = owner_q;
      bus.busy       = (state_q == LOCK);

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               owner_d = winner;
               beat_d  = '0;
               state_d = LOCK;
            end
         end
         LOCK: begin
            // Reset suppresses the write so a word is never half-accepted
            xfer                   = bus.req_valid[owner_q] && !bus.fifo_full && !reset;
            bus.fifo_wr            = xfer;
            bus.req_ready[owner_q] = xfer;
            if (!bus.req_valid[owner_q]) begin
               state_d      = IDLE;
               last_grant_d = owner_q;
               beat_d       = '0;
            end else if (xfer) begin
               if (beat_q == last_beat) begin
                  state_d      = IDLE;
                  last_grant_d = owner_q;
                  beat_d       = '0;
               end else begin
                  beat_d = beat_q + cnt_width'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes (owner, data, cycle)
// are queued when lanes are loaded and checked as the FIFO write occurs.
module tb_fifo_wr_arbiter;
   localparam int unsigned num_req    = 4;
   localparam int unsigned data_width = 8;
   localparam int unsigned burst_max  = 4;

   typedef struct {
      int id;
      int data;
      int cyc;
   } exp_t;

   logic clk;
   logic reset;

   fifo_wr_arbiter_if #(.num_req(num_req), .data_width(data_width)) bus ();

   fifo_wr_arbiter #(
      .num_req   (num_req),
      .data_width(data_width),
      .burst_max (burst_max)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t       sb[$];
   logic [7:0] mem [4][16];
   int         rd [4];
   int         wr [4];
   int         cyc;
   int         rst_cyc;
   int         full_from;
   int         full_to;
   int         stall_id;
   bit         hard_rst;
   int         n_cmp;
   int         n_err;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic load(input int lane, input logic [7:0] d);
      mem[lane][wr[lane]] = d;
      wr[lane]++;
   endtask

   task automatic expect_wr(input int id, input int d, input int c);
      exp_t e;
      e.id = id; e.data = d; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
   endtask

   // Present each lane's head word; full/reset follow the scenario's cycle window
   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bus.req_valid[i]      = (rd[i] < wr[i]);
         bus.req_data[i*8 +: 8] = (rd[i] < wr[i]) ? mem[i][rd[i] % 16] : 8'h00;
      end
      bus.fifo_full = (cyc >= full_from) && (cyc <= full_to);
      reset         = hard_rst || (cyc == rst_cyc);
   endtask

   task automatic monitor();
      exp_t e;
      if (reset) begin
         chk("rst_wr", 32'(bus.fifo_wr), 32'(0));
         chk("rst_ready", 32'(bus.req_ready), 32'(0));
      end else begin
         chk("ready_onehot", 32'(bus.req_ready),
             32'(bus.fifo_wr ? (4'b0001 << bus.grant_id) : 4'b0000));
      end
      if (bus.fifo_full) begin
         chk("full_no_wr", 32'(bus.fifo_wr), 32'(0));
         if (stall_id >= 0) begin
            chk("stall_busy", 32'(bus.busy), 32'(1));
            chk("stall_owner", 32'(bus.grant_id), 32'(stall_id));
         end
      end
      if (bus.fifo_wr === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_wr", 32'(bus.fifo_wdata), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("wdata", 32'(bus.fifo_wdata), 32'(e.data));
            chk("wid", 32'(bus.grant_id), 32'(e.id));
            if (e.cyc >= 0) chk("wcyc", 32'(cyc), 32'(e.cyc));
         end
      end
   endtask

   // One clock: sample at negedge, retire accepted words, drive after posedge
   task automatic tick();
      logic [3:0] acc;
      @(negedge clk);
      monitor();
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i] === 1'b1) rd[i]++;
      cyc++;
      drive();
   endtask

   task automatic run(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (sb.size() > 0 && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_drained"}, 32'(sb.size()), 32'(0));
      sb.delete();
      for (int i = 0; i < 3; i++) tick();
      chk({tag, "_idle"}, 32'(bus.busy), 32'(0));
      for (int i = 0; i < 4; i++) chk({tag, "_lane_empty"}, 32'(rd[i]), 32'(wr[i]));
   endtask

   task automatic start();
      cyc = 0;
      drive();
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      cyc = 0; rst_cyc = -1; full_from = -1; full_to = -2; stall_id = -1;
      hard_rst = 1'b1;
      clear_lanes();

      // Reset with every requester valid
      for (int i = 0; i < 4; i++) load(i, 8'(8'hA0 + i));
      drive();
      tick();
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_grant", 32'(bus.grant_id), 32'(0));
      chk("rst_wdata", 32'(bus.fifo_wdata), 32'hA0);
      tick();
      hard_rst = 1'b0;
      for (int i = 0; i < 4; i++) expect_wr(i, 8'hA0 + i, 1 + 3*i);
      start();
      run("reset_rr", 60);

      // Single requester, two full bursts with one bubble between
      clear_lanes();
      for (int k = 0; k < 8; k++) begin
         load(2, 8'(8'h10 + k));
         expect_wr(2, 8'h10 + k, (k < 4) ? 1 + k : 6 + (k - 4));
      end
      start();
      run("single", 60);

      // Round-robin from a fresh reset: 0,1,2,3,0
      clear_lanes();
      hard_rst = 1'b1;
      drive();
      tick();
      hard_rst = 1'b0;
      for (int k = 0; k < 8; k++) load(0, 8'(8'h40 + k));
      for (int i = 1; i < 4; i++)
         for (int k = 0; k < 4; k++) load(i, 8'(8'h40 + 16*i + k));
      for (int g = 0; g < 5; g++)
         for (int k = 0; k < 4; k++)
            expect_wr(g % 4, 8'h40 + 16*(g % 4) + ((g == 4) ? 4 + k : k), 1 + 5*g + k);
      start();
      run("round_robin", 80);

      // FIFO full for three cycles after the second word
      clear_lanes();
      full_from = 3; full_to = 5; stall_id = 1;
      for (int k = 0; k < 4; k++) load(1, 8'(8'h60 + k));
      expect_wr(1, 8'h60, 1);
      expect_wr(1, 8'h61, 2);
      expect_wr(1, 8'h62, 6);
      expect_wr(1, 8'h63, 7);
      start();
      run("full_stall", 60);
      full_from = -1; full_to = -2; stall_id = -1;
      drive();

      // Owner drops valid after two words; next grant wraps to 0, then 1
      clear_lanes();
      load(3, 8'h70); load(3, 8'h71);
      load(0, 8'h80); load(0, 8'h81);
      load(1, 8'h88); load(1, 8'h89);
      expect_wr(3, 8'h70, 1);
      expect_wr(3, 8'h71, 2);
      expect_wr(0, 8'h80, 5);
      expect_wr(0, 8'h81, 6);
      expect_wr(1, 8'h88, 9);
      expect_wr(1, 8'h89, 10);
      start();
      run("early_drop", 60);

      // Reset during the third word of requester 2
      clear_lanes();
      rst_cyc = 3;
      for (int k = 0; k < 4; k++) load(2, 8'(8'h90 + k));
      load(0, 8'hB0); load(0, 8'hB1);
      expect_wr(2, 8'h90, 1);
      expect_wr(2, 8'h91, 2);
      expect_wr(0, 8'hB0, 5);
      expect_wr(0, 8'hB1, 6);
      expect_wr(2, 8'h92, 9);
      expect_wr(2, 8'h93, 10);
      start();
      run("reset_mid", 60);
      rst_cyc = -1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
